lights_sequencer: RTL and testbench
===================================

# lights_sequencer

Controller for the `lights` colour-cycling block: owns its `button` and `rst` inputs and decides when the colour advances. It offers three services: hold, timed auto-advance, and a counted step request with a valid/ready handshake. An optional self-check compares the returned colour against an internally tracked expected colour. Sits between the top-level control logic and one `lights` instance.

## Interface
- DWELL_W, 8, width of the auto-advance dwell count
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low (rst=0 resets on the next rising edge)
- mode  in  2  00 HOLD, 01 AUTO, 10 STEP, 11 CLEAR
- dwell  in  DWELL_W  idle cycles per colour in AUTO; 0 is treated as 1
- step_valid  in  1  step request valid
- step_count  in  3  number of colour advances requested
- step_ready  out  1  high in IDLE when mode==STEP
- colour  in  3  current colour returned from `lights`
- light_button  out  1  to `lights.button`; one-cycle pulse per advance
- light_rst  out  1  to `lights.rst`; active-high
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a STEP or CLEAR sequence completes
- err  out  1  sticky check failure; cleared only by rst

## Operation
- Colour sequence: 001→010→011→100→101→110→001. Values 000 and 111 are illegal.
- `exp` register: the expected colour.
  - next(exp) = 001 if exp==110, else exp+1.
  - `exp` is 3 bits; there is no other wrap.
- States:
  - IDLE: the resting state.
  - WAIT: counts down the dwell time in AUTO.
  - PULSE: light_button=1 for one cycle; exp<=next(exp).
  - CHECK: compares colour against exp.
  - CLR: light_rst=1 for one cycle; exp<=001.
- IDLE, by mode:
  - HOLD: stay in IDLE.
  - AUTO: load the counter with max(dwell,1), go to WAIT.
  - STEP: assert step_ready. On step_valid&&step_ready:
    - capture `rem`=step_count;
    - if rem==0, pulse done next cycle and stay in IDLE;
    - otherwise go to PULSE.
  - CLEAR: go to CLR.
- WAIT:
  - decrement the counter each cycle; go to PULSE when it reaches 1;
  - if mode≠AUTO, abandon and go to IDLE (no pulse);
  - if mode==CLEAR, go to CLR.
- PULSE → CHECK.
- CHECK:
  - if colour≠exp, or colour∈{000,111}, set err;
  - AUTO path: reload the counter and go to WAIT;
  - STEP path: rem--; if rem==0, pulse done and go to IDLE, else go to PULSE;
  - CLR path: pulse done and go to IDLE.
- CLR → CHECK.
- mode changes are ignored in PULSE and CHECK. A STEP sequence always runs to completion; it is never cut short.

## Timing
- During reset:
  - light_rst=1; light_button=0, step_ready=0, busy=0, done=0, err=0;
  - exp=001; state=IDLE on release.
- First cycle after release: light_rst=0.
- STEP handshake:
  - a request accepted at edge T gives the first light_button pulse in cycle T+1;
  - with check compiled in, each advance takes 2 cycles (PULSE, CHECK);
  - done is high in cycle T+2n+1, and step_ready returns the same cycle.
- AUTO period: max(dwell,1)+2 cycles between light_button pulses (check compiled in).
- CHECK samples colour one cycle after PULSE: `lights` updates colour at the edge that samples button.
- rst asserted mid-sequence aborts the sequence at the next edge. There is no done pulse; outputs take their reset values.

## Configuration
- LIGHTS_SEQ_CHECK_EN defined:
  - CHECK state present; err active as above.
- LIGHTS_SEQ_CHECK_EN undefined:
  - CHECK removed; PULSE and CLR branch directly as CHECK would;
  - err tied 0; colour unused;
  - STEP n takes n+1 cycles to done; AUTO period is max(dwell,1)+1.

## Structure
- Shared package `lights_pkg` holds:
  - mode encodings MODE_HOLD/AUTO/STEP/CLEAR;
  - colour constants COL_FIRST=3'b001, COL_LAST=3'b110;
  - state enum;
  - next-colour function.
- Sub-module `lights_dwell_timer`: loadable DWELL_W down-counter with a `load`/`expire` interface, instantiated once.

## Test plan
- Reset, then HOLD for 20 cycles → light_rst=1 during reset then 0; light_button never high; colour stays 001; err=0.
- STEP, step_count=3 accepted at T → pulses at T+1, T+3, T+5; done at T+7; colour=100; err=0.
- STEP, step_count=0 → done one cycle after accept; no pulse; colour unchanged.
- AUTO, dwell=2, run 6 advances → pulses every 4 cycles; colour walks 001…110→001 with wrap; never 000/111.
- AUTO, then CLEAR during WAIT → light_rst pulse, colour=001, done pulse, IDLE.
- Force colour to 111 after a PULSE (check build) → err=1 and stays 1 until rst=0.

Source files
------------

// File: rtl/lights_pkg.sv
// lights_pkg: shared encodings for the lights sequencer.
// Mode, colour and state types plus the colour step function.
package lights_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_AUTO  = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  localparam logic [2:0] COL_FIRST = 3'b001;
  localparam logic [2:0] COL_LAST  = 3'b110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PULSE,
    ST_CHECK,
    ST_CLR
  } state_t;

  // Which service started the current sequence.
  typedef enum logic [1:0] {
    PATH_AUTO,
    PATH_STEP,
    PATH_CLR
  } path_t;

  function automatic logic [2:0] col_next(input logic [2:0] c);
    return (c == COL_LAST) ? COL_FIRST : c + 3'd1;
  endfunction

  function automatic logic col_bad(input logic [2:0] c);
    return (c == 3'b000) || (c == 3'b111);
  endfunction

endpackage

// File: rtl/lights_sequencer_if.sv
// lights_sequencer_if: step request valid/ready handshake.
// master issues counted step requests, slave accepts them.
interface lights_sequencer_if;

  logic       step_valid;
  logic [2:0] step_count;
  logic       step_ready;

  modport master (
    output step_valid,
    output step_count,
    input  step_ready
  );

  modport slave (
    input  step_valid,
    input  step_count,
    output step_ready
  );

endinterface

// File: rtl/lights_dwell_timer.sv
// lights_dwell_timer: loadable down-counter for the AUTO dwell.
// A load of 0 is promoted to 1; expire is high when the count is 1.
module lights_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dec,
  input  logic [DWELL_W-1:0] value,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (value == '0) ? DWELL_W'(1) : value;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - DWELL_W'(1);
    end
  end

  assign expire = (cnt == DWELL_W'(1));

endmodule

// File: rtl/lights_sequencer.sv
// lights_sequencer: hold / auto / step / clear controller for lights.
// Define LIGHTS_SEQ_CHECK_EN to compile in the colour self-check.
module lights_sequencer
  import lights_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  lights_sequencer_if.slave  step,
  input  logic [2:0]         colour,
  output logic               light_button,
  output logic               light_rst,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t     state;
  path_t      path;
  logic [2:0] exp;
  logic [2:0] rem;
  logic       ready_q;
  logic       fin;
  logic       t_load;
  logic       t_dec;
  logic       t_expire;

  // fin marks the cycle in which an advance or clear resolves.
`ifdef LIGHTS_SEQ_CHECK_EN
  logic err_q;
  assign fin = (state == ST_CHECK);
  assign err = err_q;
`else
  wire unused_colour = ^colour;
  assign fin = (state == ST_PULSE) || (state == ST_CLR);
  assign err = 1'b0;
`endif

  assign step.step_ready = ready_q;

  assign t_load = (state == ST_IDLE && mode == MODE_AUTO) ||
                  (fin && path == PATH_AUTO);
  assign t_dec  = (state == ST_WAIT) && (mode == MODE_AUTO) &&
                  !t_expire;

  lights_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (t_load),
    .dec    (t_dec),
    .value  (dwell),
    .expire (t_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      path         <= PATH_STEP;
      exp          <= COL_FIRST;
      rem          <= '0;
      ready_q      <= 1'b0;
      light_button <= 1'b0;
      light_rst    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef LIGHTS_SEQ_CHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      light_button <= 1'b0;
      light_rst    <= 1'b0;
      done         <= 1'b0;
      if (state == ST_PULSE) exp <= col_next(exp);
      if (state == ST_CLR)   exp <= COL_FIRST;
`ifdef LIGHTS_SEQ_CHECK_EN
      if (state == ST_CHECK &&
          (colour != exp || col_bad(colour)))
        err_q <= 1'b1;
`endif
      unique case (1'b1)
        state == ST_IDLE: begin
          busy    <= 1'b0;
          ready_q <= (mode == MODE_STEP);
          unique case (mode)
            MODE_HOLD: ;
            MODE_AUTO: begin
              path    <= PATH_AUTO;
              state   <= ST_WAIT;
              busy    <= 1'b1;
              ready_q <= 1'b0;
            end
            MODE_STEP: begin
              if (step.step_valid && ready_q) begin
                rem <= step.step_count;
                if (step.step_count == 3'd0) begin
                  done <= 1'b1;
                end else begin
                  path         <= PATH_STEP;
                  state        <= ST_PULSE;
                  light_button <= 1'b1;
                  busy         <= 1'b1;
                  ready_q      <= 1'b0;
                end
              end
            end
            MODE_CLEAR: begin
              path      <= PATH_CLR;
              state     <= ST_CLR;
              light_rst <= 1'b1;
              busy      <= 1'b1;
              ready_q   <= 1'b0;
            end
          endcase
        end
        state == ST_WAIT: begin
          if (mode == MODE_CLEAR) begin
            path      <= PATH_CLR;
            state     <= ST_CLR;
            light_rst <= 1'b1;
          end else if (mode != MODE_AUTO) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            ready_q <= (mode == MODE_STEP);
          end else if (t_expire) begin
            state        <= ST_PULSE;
            light_button <= 1'b1;
          end
        end
        fin: begin
          unique case (path)
            PATH_AUTO: state <= ST_WAIT;
            PATH_STEP: begin
              if (rem == 3'd1) begin
                rem     <= '0;
                done    <= 1'b1;
                state   <= ST_IDLE;
                busy    <= 1'b0;
                ready_q <= (mode == MODE_STEP);
              end else begin
                rem          <= rem - 3'd1;
                state        <= ST_PULSE;
                light_button <= 1'b1;
              end
            end
            default: begin
              done    <= 1'b1;
              state   <= ST_IDLE;
              busy    <= 1'b0;
              ready_q <= (mode == MODE_STEP);
            end
          endcase
        end
        default: begin
`ifdef LIGHTS_SEQ_CHECK_EN
          state <= ST_CHECK;
`else
          state <= ST_IDLE;
          busy  <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lights_sequencer.sv
// tb_lights_sequencer: scoreboard bench with a behavioural lights model.
// Expectations adapt to LIGHTS_SEQ_CHECK_EN (advance = 2 or 1 cycles).
module tb_lights_sequencer;
  import lights_pkg::*;

`ifdef LIGHTS_SEQ_CHECK_EN
  localparam int ADV = 2;
`else
  localparam int ADV = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] dwell;
  logic [2:0] colour = 3'b000;
  logic       light_button, light_rst, busy, done, err;
  logic       force_bad;
  logic [2:0] exp_col;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  lights_sequencer_if ifc ();

  lights_sequencer #(.DWELL_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .dwell        (dwell),
    .step         (ifc.slave),
    .colour       (colour),
    .light_button (light_button),
    .light_rst    (light_rst),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2:0] nxt(input logic [2:0] c);
    case (c)
      3'b001: return 3'b010;
      3'b010: return 3'b011;
      3'b011: return 3'b100;
      3'b100: return 3'b101;
      3'b101: return 3'b110;
      default: return 3'b001;
    endcase
  endfunction

  // Behavioural lights: synchronous reset, advance on button.
  always @(posedge clk) begin
    if (light_rst) colour <= 3'b001;
    else if (light_button) colour <= force_bad ? 3'b111 : nxt(colour);
  end

  task automatic test_reset();
    int pulses;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({light_rst, light_button, ifc.step_ready, busy, done, err} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 100000",
               {light_rst, light_button, ifc.step_ready, busy, done, err});
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (light_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL release_lrst: got %b want 0", light_rst);
    end
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (light_button) pulses++;
    end
    n_checks++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL hold_pulses: got %0d want 0", pulses);
    end
    n_checks++;
    if (colour !== 3'b001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_state: got col=%b err=%b want 001/0", colour, err);
    end
    exp_col = 3'b001;
  endtask

  task automatic test_step(input int n, input string nm);
    int q[$];
    int t, exp_done, bud;
    logic got;
    logic [2:0] c;
    mode = MODE_STEP;
    bud = 0;
    do begin
      @(negedge clk);
      bud++;
    end while (!ifc.step_ready && bud < 10);
    n_checks++;
    if (ifc.step_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: got %b want 1", nm, ifc.step_ready);
    end
    ifc.step_valid = 1'b1;
    ifc.step_count = 3'(n);
    t = cyc + 1;
    for (int i = 0; i < n; i++) q.push_back(t + ADV * i);
    exp_done = t + ADV * n;
    c = exp_col;
    for (int i = 0; i < n; i++) c = nxt(c);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (cyc == t) ifc.step_valid = 1'b0;
      if (light_button) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %s_pulse: extra pulse at %0d", nm, cyc);
        end else begin
          int e;
          e = q.pop_front();
          if (cyc !== e) begin
            n_fail++;
            $display("FAIL %s_pulse: got cycle %0d want %0d", nm, cyc, e);
          end
        end
      end
      if (done) begin
        got = 1'b1;
        n_checks++;
        if (cyc !== exp_done || ifc.step_ready !== 1'b1 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_done: got cyc=%0d rdy=%b busy=%b want %0d/1/0",
                   nm, cyc, ifc.step_ready, busy, exp_done);
        end
      end
    end
    ifc.step_valid = 1'b0;
    n_checks++;
    if (!got || q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_complete: got done=%b left=%0d want 1/0", nm, got, q.size());
    end
    n_checks++;
    if (colour !== c || err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_colour: got %b err=%b want %b err=0", nm, colour, err, c);
    end
    exp_col = c;
    mode = MODE_HOLD;
  endtask

  task automatic test_auto();
    int q[$];
    int e0, pulses, bad, extra;
    dwell = 8'd2;
    mode = MODE_AUTO;
    e0 = cyc + 1;
    for (int k = 0; k < 6; k++) q.push_back(e0 + 2 + k * (2 + ADV));
    pulses = 0;
    bad = 0;
    for (int k = 0; k < 80 && pulses < 6; k++) begin
      @(negedge clk);
      if (colour == 3'b000 || colour == 3'b111) bad++;
      if (light_button) begin
        int e;
        pulses++;
        e = q.pop_front();
        n_checks++;
        if (cyc !== e || colour !== exp_col) begin
          n_fail++;
          $display("FAIL auto_pulse%0d: got cyc=%0d col=%b want %0d/%b",
                   pulses, cyc, colour, e, exp_col);
        end
        exp_col = nxt(exp_col);
        if (pulses == 6) mode = MODE_HOLD;
      end
    end
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (light_button) extra++;
      if (colour == 3'b000 || colour == 3'b111) bad++;
    end
    n_checks++;
    if (pulses !== 6 || extra !== 0 || bad !== 0) begin
      n_fail++;
      $display("FAIL auto_count: got pulses=%0d extra=%0d bad=%0d want 6/0/0",
               pulses, extra, bad);
    end
    n_checks++;
    if (colour !== exp_col || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_end: got col=%b busy=%b err=%b want %b/0/0",
               colour, busy, err, exp_col);
    end
  endtask

  task automatic test_clear_in_wait();
    int c0, lrst_at, done_at, pulses;
    dwell = 8'd5;
    mode = MODE_AUTO;
    repeat (3) @(negedge clk);
    mode = MODE_CLEAR;
    c0 = cyc + 1;
    lrst_at = -1;
    done_at = -1;
    pulses = 0;
    for (int k = 0; k < 20 && done_at < 0; k++) begin
      @(negedge clk);
      if (light_rst && lrst_at < 0) lrst_at = cyc;
      if (light_button) pulses++;
      if (done) begin
        done_at = cyc;
        mode = MODE_HOLD;
      end
    end
    mode = MODE_HOLD;
    n_checks++;
    if (lrst_at !== c0 || done_at !== c0 + ADV || pulses !== 0) begin
      n_fail++;
      $display("FAIL clear_timing: got lrst=%0d done=%0d pulses=%0d want %0d/%0d/0",
               lrst_at, done_at, pulses, c0, c0 + ADV);
    end
    @(negedge clk);
    n_checks++;
    if (colour !== 3'b001 || busy !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_end: got col=%b busy=%b err=%b want 001/0/0",
               colour, busy, err);
    end
    exp_col = 3'b001;
  endtask

  task automatic test_abort();
    int t, pulses;
    mode = MODE_STEP;
    repeat (2) @(negedge clk);
    ifc.step_valid = 1'b1;
    ifc.step_count = 3'd7;
    t = cyc + 1;
    pulses = 0;
    for (int k = 0; k < 30 && pulses < 2; k++) begin
      @(negedge clk);
      if (cyc == t) ifc.step_valid = 1'b0;
      if (light_button) pulses++;
    end
    ifc.step_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({light_rst, light_button, busy, done, ifc.step_ready} !== 5'b10000) begin
      n_fail++;
      $display("FAIL abort_reset: got %b want 10000",
               {light_rst, light_button, busy, done, ifc.step_ready});
    end
    rst = 1'b1;
    mode = MODE_HOLD;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) pulses = 99;
    end
    n_checks++;
    if (light_rst !== 1'b0 || colour !== 3'b001 || pulses !== 2) begin
      n_fail++;
      $display("FAIL abort_after: got lrst=%b col=%b pulses=%0d want 0/001/2",
               light_rst, colour, pulses);
    end
    exp_col = 3'b001;
  endtask

`ifdef LIGHTS_SEQ_CHECK_EN
  task automatic test_err();
    int t;
    logic got;
    force_bad = 1'b1;
    mode = MODE_STEP;
    repeat (2) @(negedge clk);
    ifc.step_valid = 1'b1;
    ifc.step_count = 3'd1;
    t = cyc + 1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (cyc == t) ifc.step_valid = 1'b0;
      if (done) got = 1'b1;
    end
    ifc.step_valid = 1'b0;
    force_bad = 1'b0;
    mode = MODE_HOLD;
    n_checks++;
    if (!got || err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: got done=%b err=%b want 1/1", got, err);
    end
    repeat (6) @(negedge clk);
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got %b want 0", err);
    end
    rst = 1'b1;
    @(negedge clk);
    exp_col = 3'b001;
  endtask
`endif

  initial begin
    rst = 1'b0;
    mode = MODE_HOLD;
    dwell = 8'd0;
    force_bad = 1'b0;
    exp_col = 3'b001;
    ifc.step_valid = 1'b0;
    ifc.step_count = 3'd0;
    test_reset();
    test_step(3, "step3");
    test_step(0, "step0");
    test_step(2, "b2b_a");
    test_step(5, "b2b_b");
    test_auto();
    test_clear_in_wait();
    test_abort();
`ifdef LIGHTS_SEQ_CHECK_EN
    test_err();
`endif
    test_step(7, "step7");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
